dmem_bytelane: RTL



---
 rtl/dmem_pkg.sv | 21 ++
 rtl/dmem_lane_align.sv | 96 +++++++++
 rtl/dmem_bytelane.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the byte-lane data memory:
//   - RV32 load/store funct3 encodings used to select access size and sign
//   - state type of the post-reset clear sweep
// ----------------------------------------------------------------------------
package dmem_pkg;

    // funct3 encodings (bit 2 = unsigned load, bits [1:0] = log2 of size)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// ----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational lane steering for byte/half/word accesses.
//   i_funct3       : access size/sign (RV32 load/store encoding)
//   i_offset       : byte offset within the word (Address[1:0])
//   i_raw_word     : current contents of the addressed word
//   i_write_data   : right-aligned store data
//   o_byte_en      : lanes written by a store (not gated by fault)
//   o_store_word   : store data replicated onto every candidate lane
//   o_load_value   : sign/zero-extended load result
//   o_load_fault   : funct3/offset illegal for a load
//   o_store_fault  : funct3/offset illegal for a store
// ----------------------------------------------------------------------------
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_raw_word,
    input  logic [31:0] i_write_data,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_store_word,
    output logic [31:0] o_load_value,
    output logic        o_load_fault,
    output logic        o_store_fault
);

    logic        w_misaligned;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Natural alignment depends only on the size field, shared by loads and stores.
    always_comb begin
        w_misaligned = 1'b0;
        case (i_funct3[1:0])
            2'b01:   w_misaligned = i_offset[0];
            2'b10:   w_misaligned = (i_offset != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        o_load_fault = 1'b1;
        case (i_funct3)
            F3_B, F3_BU:       o_load_fault = 1'b0;
            F3_H, F3_HU, F3_W: o_load_fault = w_misaligned;
            default:           o_load_fault = 1'b1;
        endcase
    end

    always_comb begin
        o_store_fault = 1'b1;
        case (i_funct3)
            F3_B:       o_store_fault = 1'b0;
            F3_H, F3_W: o_store_fault = w_misaligned;
            default:    o_store_fault = 1'b1;
        endcase
    end

    always_comb begin
        o_byte_en = 4'b0000;
        case (i_funct3)
            F3_B:    o_byte_en = 4'b0001 << i_offset;
            F3_H:    o_byte_en = i_offset[1] ? 4'b1100 : 4'b0011;
            F3_W:    o_byte_en = 4'b1111;
            default: o_byte_en = 4'b0000;
        endcase
    end

    // Replicating the data onto every lane avoids a shifter; the byte
    // enables pick the lanes that actually land in memory.
    always_comb begin
        o_store_word = i_write_data;
        case (i_funct3[1:0])
            2'b00:   o_store_word = {4{i_write_data[7:0]}};
            2'b01:   o_store_word = {2{i_write_data[15:0]}};
            default: o_store_word = i_write_data;
        endcase
    end

    assign w_byte = i_raw_word[{i_offset, 3'b000} +: 8];
    assign w_half = i_offset[1] ? i_raw_word[31:16] : i_raw_word[15:0];

    always_comb begin
        o_load_value = 32'h0000_0000;
        case (i_funct3)
            F3_B:    o_load_value = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_load_value = {24'h000000, w_byte};
            F3_H:    o_load_value = {{16{w_half[15]}}, w_half};
            F3_HU:   o_load_value = {16'h0000, w_half};
            F3_W:    o_load_value = i_raw_word;
            default: o_load_value = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_bytelane.sv
// ----------------------------------------------------------------------------
// dmem_bytelane
// RV32 MEM-stage data memory with byte/half/word access, fault detection and
// a sequential zeroing sweep after reset.
//   clk          : system clock, all state on rising edge
//   reset        : synchronous active-high reset
//   MemWrite     : store request this cycle
//   MemRead      : load request this cycle
//   funct3       : access size/sign
//   Address      : byte address (aliases modulo DEPTH*4)
//   writeData    : right-aligned store data
//   readData     : combinational, extended load result (0 if idle/faulting)
//   ready        : memory accepts accesses
//   access_fault : one-cycle pulse after a misaligned/illegal access
// ----------------------------------------------------------------------------
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int DEPTH          = 64,
    parameter int IDX_W          = $clog2(DEPTH),
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [2:0]  funct3,
    input  logic [31:0] Address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    output logic        access_fault
);

    // Loads are combinational, so the array is read asynchronously.
    logic [31:0]      r_mem [DEPTH];
    state_t           r_state;
    state_t           w_state_next;
    logic [IDX_W-1:0] r_clr_ptr;
    logic             r_access_fault;

    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_wr_idx;
    logic [31:0]      w_raw_word;
    logic [31:0]      w_wr_word;
    logic [3:0]       w_byte_en;
    logic [31:0]      w_store_word;
    logic [31:0]      w_load_value;
    logic             w_load_fault;
    logic             w_store_fault;
    logic             w_ready;
    logic             w_clear_we;
    logic             w_store_we;
    logic             w_mem_we;
    logic             w_fault_now;
    logic             w_unused_addr;

    // Upper address bits are deliberately ignored (aliasing).
    assign w_unused_addr = ^Address[31:IDX_W+2];

    assign w_idx      = Address[IDX_W+1:2];
    assign w_raw_word = r_mem[w_idx];

    dmem_lane_align u_align (
        .i_funct3      (funct3),
        .i_offset      (Address[1:0]),
        .i_raw_word    (w_raw_word),
        .i_write_data  (writeData),
        .o_byte_en     (w_byte_en),
        .o_store_word  (w_store_word),
        .o_load_value  (w_load_value),
        .o_load_fault  (w_load_fault),
        .o_store_fault (w_store_fault)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= CLEAR;
            r_clr_ptr      <= '0;
            r_access_fault <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            if (r_state == CLEAR) begin
                r_clr_ptr <= r_clr_ptr + 1'b1;
            end
            r_access_fault <= w_fault_now;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CLEAR: begin
                if (!CLEAR_ON_RESET || (r_clr_ptr == IDX_W'(DEPTH - 1))) begin
                    w_state_next = READY;
                end
            end
            READY:   w_state_next = READY;
            default: w_state_next = CLEAR;
        endcase
    end

    // Output / datapath control
    always_comb begin
        w_ready     = (r_state == READY);
        w_clear_we  = (r_state == CLEAR) && CLEAR_ON_RESET;
        w_store_we  = w_ready && MemWrite && !w_store_fault;
        // A combined read+write faults if either half is illegal.
        w_fault_now = w_ready && ((MemRead && w_load_fault) ||
                                  (MemWrite && w_store_fault));
        readData    = 32'h0000_0000;
        if (w_ready && MemRead && !w_load_fault) begin
            readData = w_load_value;
        end
    end

    // Merge new lanes with the old word so the array has one full-word port.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign w_wr_word[gi*8 +: 8] = w_clear_we     ? 8'h00 :
                                          w_byte_en[gi]  ? w_store_word[gi*8 +: 8] :
                                                           w_raw_word[gi*8 +: 8];
        end
    endgenerate

    assign w_wr_idx = w_clear_we ? r_clr_ptr : w_idx;
    assign w_mem_we = !reset && (w_clear_we || w_store_we);

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_wr_idx] <= w_wr_word;
        end
    end

    assign ready        = w_ready;
    assign access_fault = r_access_fault;

endmodule
